// File: rtl/shift_seq_ctrl.sv
// Command sequencer for the 8-op shift register: drives ctrl/data_in for N cycles, then reports Q.
// Optional abort input and rsp_aborted flag are built in when SHIFT_SEQ_ABORT_EN is defined.
module shift_seq_ctrl #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CNT_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [2:0]            cmd_op_i,
   input  logic [CNT_WIDTH-1:0]  cmd_cnt_i,
   input  logic [DATA_WIDTH-1:0] cmd_data_i,
   output logic [2:0]            sr_ctrl_o,
   output logic [DATA_WIDTH-1:0] sr_data_in_o,
   input  logic [DATA_WIDTH-1:0] sr_q_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_data_o,
`ifdef SHIFT_SEQ_ABORT_EN
   input  logic                  abort_i,
   output logic                  rsp_aborted_o,
`endif
   output logic                  busy_o
);

   localparam logic [2:0] OpClear  = 3'b000;
   localparam logic [2:0] OpLoad   = 3'b001;
   localparam logic [2:0] OpSerial = 3'b101;

   localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StResp
   } state_e;

   state_e                state_q;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic [2:0]            op_q;
   logic [DATA_WIDTH-1:0] shadow_q;
   logic                  cmd_ready_q;
   logic                  rsp_valid_q;
   logic                  busy_q;
   logic [CNT_WIDTH-1:0]  eff_cnt;
   logic                  run_abort;
   logic                  drive_op;

`ifdef SHIFT_SEQ_ABORT_EN
   logic aborted_q;
   assign run_abort     = abort_i;
   assign rsp_aborted_o = aborted_q;
`else
   assign run_abort = 1'b0;
`endif

   // Clear and load always take exactly one edge regardless of the requested count.
   assign eff_cnt = ((cmd_op_i == OpClear) || (cmd_op_i == OpLoad)) ? CntOne : cmd_cnt_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         op_q        <= OpClear;
         shadow_q    <= '0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef SHIFT_SEQ_ABORT_EN
         aborted_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            StIdle: begin
               if (cmd_valid_i) begin
                  op_q        <= cmd_op_i;
                  cnt_q       <= eff_cnt;
                  shadow_q    <= cmd_data_i;
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
`ifdef SHIFT_SEQ_ABORT_EN
                  aborted_q   <= 1'b0;
`endif
                  if (eff_cnt == '0) begin
                     state_q     <= StResp;
                     rsp_valid_q <= 1'b1;
                  end else begin
                     state_q <= StRun;
                  end
               end
            end
            StRun: begin
               if (run_abort) begin
                  state_q     <= StResp;
                  rsp_valid_q <= 1'b1;
`ifdef SHIFT_SEQ_ABORT_EN
                  aborted_q   <= 1'b1;
`endif
               end else begin
                  cnt_q <= cnt_q - CntOne;
                  if (op_q == OpSerial) begin
                     shadow_q <= {shadow_q[0], shadow_q[DATA_WIDTH-1:1]};
                  end
                  // RUN is only entered with a non-zero count, so this exit prevents underflow.
                  if (cnt_q == CntOne) begin
                     state_q     <= StResp;
                     rsp_valid_q <= 1'b1;
                  end
               end
            end
            StResp: begin
               if (rsp_ready_i) begin
                  state_q     <= StIdle;
                  rsp_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  cmd_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= StIdle;
               rsp_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               cmd_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign drive_op = (state_q == StRun) && !run_abort;

   // Outside an active op cycle the register reloads its own output to hold its value.
   always_comb begin
      sr_ctrl_o    = OpLoad;
      sr_data_in_o = sr_q_i;
      if (drive_op) begin
         sr_ctrl_o = op_q;
         case (op_q)
            OpLoad:   sr_data_in_o = shadow_q;
            OpSerial: sr_data_in_o = {{(DATA_WIDTH-1){1'b0}}, shadow_q[0]};
            default:  sr_data_in_o = '0;
         endcase
      end
   end

   assign cmd_ready_o = cmd_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = sr_q_i;
   assign busy_o      = busy_q;

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Command sequencer for the team's 8-op shift register (ctrl encodings 000 clear, 001 load, 010 logical right, 011 logical left, 100 arithmetic right, 101 serial-in right, 110 rotate right, 111 rotate left).
- Accepts {op, count, data} commands over a valid/ready handshake and drives the register's ctrl/data_in for the required number of cycles.
- Holds the register between commands by driving a load of its own output.
- Returns the final register value on a valid/ready response channel.

Parameters:
- DATA_WIDTH, 8: shift register width; must be >= 2.
- CNT_WIDTH, 4: width of the shift-count field.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  3  shift register opcode.
- cmd_cnt  input  CNT_WIDTH  number of shift cycles.
- cmd_data  input  DATA_WIDTH  load value or serial-in bit source.
- sr_ctrl  output  3  to shift register ctrl.
- sr_data_in  output  DATA_WIDTH  to shift register data_in.
- sr_q  input  DATA_WIDTH  from shift register Q.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  result consumed.
- rsp_data  output  DATA_WIDTH  final register value.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset and clock: reset rst_n is asynchronous and active-low; the clock is clk.
- State machine: IDLE, RUN, RESP.
- Reset values: state = IDLE; remaining count = 0; op = 000; data shadow = 0; cmd_ready = 1; rsp_valid = 0; busy = 0.
- Reset mid-operation: any state returns to IDLE immediately, and no response is emitted.
- Hold encoding: in IDLE and RESP, sr_ctrl = 001 and sr_data_in = sr_q, so the register keeps its value.
- Command acceptance:
  - cmd_ready = (state == IDLE).
  - On a clock edge with cmd_valid & cmd_ready, the controller latches op, effective count and data shadow.
- Effective count:
  - op 000 or 001: forced to 1, regardless of cmd_cnt.
  - Other ops: equal to cmd_cnt.
- Transition from IDLE: effective count 0 goes to RESP; otherwise to RUN.
- RUN, per cycle:
  - sr_ctrl = latched op; remaining count decrements at each edge.
  - When remaining count is 1 at an edge, the next state is RESP.
  - The register therefore receives exactly the effective count of op edges.
- RUN, sr_data_in by op:
  - op 001: sr_data_in = latched data.
  - op 101: sr_data_in = {DATA_WIDTH-1 zeros, shadow[0]}; the shadow rotates right by 1 each RUN edge, so bits are fed LSB first and wrap after DATA_WIDTH edges.
  - Other ops: sr_data_in = 0.
- RESP:
  - rsp_valid = 1 and rsp_data = sr_q, which is stable because the register is held.
  - On rsp_ready, the next state is IDLE.
  - While rsp_ready is low, rsp_valid and rsp_data stay stable.
- Latency: command accepted at edge E0; op edges E1..EN; rsp_valid high in the cycle after EN. With N = 0, rsp_valid is high in the cycle after E0.
- Back-to-back: a new command can be accepted one cycle after the response handshake, not in the same cycle.
- Widths: the count never underflows; a CNT_WIDTH all-ones count produces 2^CNT_WIDTH-1 edges.

Optional Feature:
- Macro: SHIFT_SEQ_ABORT_EN.
- When defined, the block adds input abort (1 bit) and output rsp_aborted (1 bit, reset 0).
- abort sampled high in RUN:
  - That cycle drives hold instead of the op.
  - Next state is RESP, with rsp_aborted = 1 for that response.
- rsp_aborted clears on the next command accept.
- abort is ignored outside RUN.
- When not defined, there are no such ports and RUN always completes.

Test Plan:
- Load: op 001, data 0xA5 → one cycle of sr_ctrl=001 with sr_data_in=0xA5; next cycle rsp_valid=1, rsp_data=0xA5.
- Logical right: after loading 0xA5, op 010, cnt 3 → exactly 3 cycles of sr_ctrl=010; rsp_data=0x14; cmd_ready low throughout.
- Arithmetic right: after loading 0x96, op 100, cnt 2 → rsp_data=0xE5.
- Serial-in: after clear (op 000), op 101, cnt 8, data 0x3C → sr_data_in[0] sequence 0,0,1,1,1,1,0,0; rsp_data=0x3C.
- Zero count and backpressure: op 111, cnt 0 on 0x81 → no 111 cycles and rsp_valid in the next cycle; hold rsp_ready low 3 cycles → rsp_valid and rsp_data=0x81 stable, sr_ctrl=001; rsp_ready high → IDLE, cmd_ready=1.
- Reset mid-run: op 110, cnt 10, assert rst_n low during the 4th RUN cycle → immediate IDLE, rsp_valid=0, cmd_ready=1, busy=0. With SHIFT_SEQ_ABORT_EN: abort in the 2nd RUN cycle → exactly 1 op edge, rsp_aborted=1.
